// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared types and constants for the instruction encoder
//
// Holds the descriptor op enum, the 11-bit opcodes, the CBZ opcode, the NOP
// word, the format field widths and the load-session FSM state enum.
package instr_encoder_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 11;
  localparam int REG_W   = 5;
  localparam int IMM_W   = 19;
  localparam int DT_W    = 9;
  localparam int CB_W    = 8;

  typedef enum logic [2:0] {
    OP_LDUR = 3'd0,
    OP_STUR = 3'd1,
    OP_CBZ  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_AND  = 3'd5,
    OP_ORR  = 3'd6
  } instr_op_t;

  localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
  localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
  localparam logic [CB_W-1:0]  OPC_CBZ  = 8'b10110100;

  // ADD XZR, XZR, XZR
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h8B1F03FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// rtl/instr_encoder_pack.sv - combinational descriptor-to-instruction-word encoder
//
// Ports:
//   op      : descriptor op (instr_op_t encoding, 7 is illegal)
//   rd/rn/rm: register fields
//   imm     : DT_address in [8:0] (LDUR/STUR), branch offset in [18:0] (CBZ)
//   word    : encoded 32-bit instruction (0 when illegal)
//   illegal : op has no encoding
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [18:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (instr_op_t'(op))
      OP_LDUR: word = {OPC_LDUR, imm[DT_W-1:0], 2'b00, rn, rd};
      OP_STUR: word = {OPC_STUR, imm[DT_W-1:0], 2'b00, rn, rd};
      OP_CBZ:  word = {OPC_CBZ, imm[IMM_W-1:0], rd};
      OP_ADD:  word = {OPC_ADD, rm, 6'b0, rn, rd};
      OP_SUB:  word = {OPC_SUB, rm, 6'b0, rn, rd};
      OP_AND:  word = {OPC_AND, rm, 6'b0, rn, rd};
      OP_ORR:  word = {OPC_ORR, rm, 6'b0, rn, rd};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - fills an instruction memory from descriptors, pads with NOPs
//
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   start, finish       : session begin / end pulses
//   in_valid, in_ready  : descriptor handshake
//   op, rd, rn, rm, imm : descriptor fields
//   we, waddr, wdata    : registered instruction-memory write port
//   done                : session complete (DONE state)
//   err                 : sticky, an illegal op was accepted
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     finish,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [4:0]               rd,
  input  logic [4:0]               rn,
  input  logic [4:0]               rm,
  input  logic [18:0]              imm,
  output logic                     we,
  output logic [$clog2(DEPTH)-1:0] waddr,
  output logic [31:0]              wdata,
  output logic                     done,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LAST_I = DEPTH - 1;
  localparam int FULL_I = DEPTH;
  // One extra bit so the counter can hold DEPTH without wrapping.
  localparam logic [AW:0] LAST_ADDR = LAST_I[AW:0];
  localparam logic [AW:0] FULL_ADDR = FULL_I[AW:0];

  state_t      state, state_nxt;
  logic [AW:0] addr;
  logic [31:0] word;
  logic        illegal;
  logic        xfer;
  logic        good_xfer;

  instr_pack u_pack (
    .op      (op),
    .rd      (rd),
    .rn      (rn),
    .rm      (rm),
    .imm     (imm),
    .word    (word),
    .illegal (illegal)
  );

  assign xfer      = in_valid && in_ready;
  assign good_xfer = xfer && !illegal;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        // A write landing on the last word ends the session even if finish
        // arrives in the same cycle; otherwise finish pads the remainder.
        if (good_xfer && addr == LAST_ADDR) state_nxt = ST_DONE;
        else if (finish) state_nxt = (addr >= FULL_ADDR) ? ST_DONE : ST_PAD;
      end
      ST_PAD:  if (addr >= LAST_ADDR) state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_LOAD) && (addr < FULL_ADDR);
    done     = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr  <= '0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      err   <= 1'b0;
    end else begin
      we <= 1'b0;
      if (start && (state == ST_IDLE || state == ST_DONE)) begin
        addr <= '0;
        err  <= 1'b0;
      end else if (state == ST_LOAD && xfer) begin
        if (illegal) begin
          err <= 1'b1;
        end else begin
          we    <= 1'b1;
          waddr <= addr[AW-1:0];
          wdata <= word;
          addr  <= addr + 1'b1;
        end
      end else if (state == ST_PAD) begin
        we    <= 1'b1;
        waddr <= addr[AW-1:0];
        wdata <= NOP_WORD;
        addr  <= addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        finish;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [18:0] imm;
  logic        we;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h8B1F03FF;

  instr_encoder #(.DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .finish   (finish),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rd       (rd),
    .rn       (rn),
    .rm       (rm),
    .imm      (imm),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [4:0] d,
                       input logic [4:0] n, input logic [4:0] m, input logic [18:0] i);
    in_valid = v; op = o; rd = d; rn = n; rm = m; imm = i;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; finish = 1'b0;
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] add_word(input logic [4:0] d, input logic [4:0] n, input logic [4:0] m);
    return {11'b10001011000, m, 6'b0, n, d};
  endfunction

  initial begin
    do_reset();
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", in_ready, 0);

    // finish in IDLE is ignored
    finish = 1'b1; tick(); finish = 1'b0; tick();
    chk("idle_finish_done", done, 0);
    chk("idle_finish_we", we, 0);

    // ADD x3 = x1 + x2
    do_start();
    chk("load_ready", in_ready, 1);
    drive(1'b1, 3'd3, 5'd3, 5'd1, 5'd2, 19'd0);
    tick();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    chk("add_we", we, 1);
    chk("add_waddr", waddr, 0);
    chk("add_wdata", wdata, 32'h8B020023);
    tick();
    chk("add_we_drop", we, 0);

    // LDUR then CBZ back to back
    do_reset(); do_start();
    drive(1'b1, 3'd0, 5'd5, 5'd2, 5'd0, 19'd8);
    tick();
    drive(1'b1, 3'd2, 5'd7, 5'd0, 5'd0, 19'd3);
    chk("ldur_waddr", waddr, 0);
    chk("ldur_wdata", wdata, 32'hF8408045);
    tick();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    chk("cbz_we", we, 1);
    chk("cbz_waddr", waddr, 1);
    chk("cbz_wdata", wdata, 32'hB4000067);

    // illegal op between two valid ops, err sticky until next start
    do_reset(); do_start();
    drive(1'b1, 3'd3, 5'd3, 5'd1, 5'd2, 19'd0);
    tick();
    chk("ill_pre_waddr", waddr, 0);
    drive(1'b1, 3'd7, 5'd1, 5'd1, 5'd1, 19'd0);
    tick();
    chk("ill_we", we, 0);
    chk("ill_err", err, 1);
    drive(1'b1, 3'd4, 5'd4, 5'd5, 5'd6, 19'd0);
    tick();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    chk("ill_post_we", we, 1);
    chk("ill_post_waddr", waddr, 1);
    chk("sub_wdata", wdata, 32'hCB0600A4);
    finish = 1'b1; tick(); finish = 1'b0;
    for (int k = 0; k < 20 && !done; k++) tick();
    chk("ill_done", done, 1);
    chk("ill_err_sticky", err, 1);
    tick();
    chk("done_we_idle", we, 0);
    do_start();
    chk("err_clear_on_start", err, 0);
    chk("restart_done_low", done, 0);
    chk("restart_ready", in_ready, 1);

    // three transfers then finish pads 3..7
    do_reset(); do_start();
    drive(1'b1, 3'd5, 5'd1, 5'd2, 5'd3, 19'd0);
    tick();
    chk("and_wdata", wdata, 32'h8A030041);
    drive(1'b1, 3'd6, 5'd1, 5'd2, 5'd3, 19'd0);
    tick();
    chk("orr_wdata", wdata, 32'hAA030041);
    drive(1'b1, 3'd1, 5'd9, 5'd10, 5'd0, 19'h7FFFF);
    tick();
    chk("stur_waddr", waddr, 2);
    chk("stur_wdata", wdata, 32'hF81FF149);
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    finish = 1'b1; tick(); finish = 1'b0;
    chk("pad_entry_we", we, 0);
    chk("pad_ready", in_ready, 0);
    for (int i = 3; i < 8; i++) begin
      tick();
      chk($sformatf("pad_we_%0d", i), we, 1);
      chk($sformatf("pad_waddr_%0d", i), waddr, i);
      chk($sformatf("pad_wdata_%0d", i), wdata, NOP);
    end
    chk("pad_done", done, 1);
    tick();
    chk("pad_after_we", we, 0);

    // transfer and finish together: transfer first, pad from next address
    do_reset(); do_start();
    drive(1'b1, 3'd3, 5'd3, 5'd1, 5'd2, 19'd0);
    finish = 1'b1; tick(); finish = 1'b0;
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    chk("fx_waddr", waddr, 0);
    chk("fx_wdata", wdata, 32'h8B020023);
    tick();
    chk("fx_pad_waddr", waddr, 1);
    chk("fx_pad_wdata", wdata, NOP);

    // eight back-to-back transfers fill the memory
    do_reset(); do_start();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'd3, 5'(i), 5'(i), 5'(i), 19'd0);
      tick();
      chk($sformatf("full_waddr_%0d", i), waddr, i);
      chk($sformatf("full_wdata_%0d", i), wdata, add_word(5'(i), 5'(i), 5'(i)));
    end
    chk("full_ready", in_ready, 0);
    chk("full_done", done, 1);
    tick();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    chk("full_no_ninth", we, 0);

    // reset during PAD aborts the session
    do_reset(); do_start();
    drive(1'b1, 3'd3, 5'd1, 5'd1, 5'd1, 19'd0);
    tick(); tick();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    finish = 1'b1; tick(); finish = 1'b0;
    for (int k = 0; k < 20 && !(we && waddr == 3'd4); k++) tick();
    chk("abort_reach_4", waddr, 4);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("abort_we", we, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("abort_idle_we_%0d", k), we, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, 64, number of instruction-memory words filled; power of two, 2..1024.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; begins a load session.
REQ-005 finish  input  1  one-cycle pulse; ends the session and pads the remaining words.
REQ-006 in_valid  input  1  an instruction descriptor is present.
REQ-007 in_ready  output  1  the encoder accepts a descriptor this cycle.
REQ-008 op  input  3  instr_op_t: LDUR=0, STUR=1, CBZ=2, ADD=3, SUB=4, AND=5, ORR=6; 7 is illegal.
REQ-009 rd  input  5  Rd or Rt.
REQ-010 rn  input  5  Rn.
REQ-011 rm  input  5  Rm.
REQ-012 imm  input  19  DT_address in bits [8:0] for LDUR/STUR; CBZ branch offset in bits [18:0].
REQ-013 we  output  1  instruction-memory write enable.
REQ-014 waddr  output  log2(DEPTH)  word address.
REQ-015 wdata  output  32  encoded instruction.
REQ-016 done  output  1  session complete.
REQ-017 err  output  1  sticky flag; an illegal op was offered.

Function
REQ-018 States SHALL be IDLE, LOAD, PAD and DONE.
REQ-019 Transitions SHALL be:
- IDLE->LOAD on start;
- LOAD->PAD on finish;
- LOAD->DONE when word DEPTH-1 is written;
- PAD->DONE when word DEPTH-1 is written;
- DONE->LOAD on start.
REQ-020 in_ready SHALL be 1 only in LOAD, and only while the next address is at most DEPTH-1.
REQ-021 A transfer SHALL occur when in_valid and in_ready are both 1; we, waddr and wdata SHALL be registered and asserted on the following cycle (latency 1).
REQ-022 R-type encoding (ADD/SUB/AND/ORR) SHALL be {opcode11, rm, 6'b0, rn, rd}.
REQ-023 D-type encoding (LDUR/STUR) SHALL be {opcode11, imm[8:0], 2'b00, rn, rd}; imm[18:9] is ignored.
REQ-024 CB-type encoding (CBZ) SHALL be {8'b10110100, imm[18:0], rd}.
REQ-025 Opcodes SHALL be:
- LDUR 11111000010
- STUR 11111000000
- ADD 10001011000
- SUB 11001011000
- AND 10001010000
- ORR 10101010000
REQ-026 The address counter SHALL start at 0 on start and increment by 1 per write; it SHALL NOT wrap.
REQ-027 A transfer with op=7 SHALL cause no write and no address increment, and SHALL set err.
REQ-028 err SHALL clear only on start or reset.
REQ-029 PAD SHALL write NOP 32'h8B1F03FF (ADD XZR,XZR,XZR), one word per cycle, from the current address through DEPTH-1.
REQ-030 If finish and a transfer occur in the same cycle, the transfer SHALL be written first and padding SHALL start at the following address.
REQ-031 If finish arrives with the address already at DEPTH, the block SHALL go directly to DONE.
REQ-032 start while in LOAD or PAD SHALL be ignored.
REQ-033 finish outside LOAD SHALL be ignored.
REQ-034 done SHALL be 1 in DONE and 0 in every other state.

Reset
REQ-035 While reset=0 at a clock edge, the block SHALL set state=IDLE, address=0, we=0, waddr=0, wdata=0, done=0, err=0 and in_ready=0.
REQ-036 A reset asserted mid-LOAD or mid-PAD SHALL abort the session with no further writes.

Structure
REQ-037 Package instr_encoder_pkg SHALL hold instr_op_t, the opcode constants, the CBZ opcode, the NOP constant and the format widths.
REQ-038 Sub-module instr_pack SHALL be a purely combinational (op, rd, rn, rm, imm) -> (word, illegal) encoder; the FSM, counter and output registers SHALL live in instr_encoder.

Verification
REQ-039 Reset, then start, then ADD rd=3 rn=1 rm=2 -> one cycle later we=1, waddr=0, wdata=32'h8B020023.
REQ-040 LDUR rd=5 rn=2 imm=8, then CBZ rd=7 imm=3 -> wdata 32'hF8408045 at address 0, then 32'hB4000067 at address 1.
REQ-041 op=7 offered between two valid ops -> err=1, the valid ops land at addresses 0 and 1, and err stays 1 until the next start.
REQ-042 DEPTH=8, three transfers, then finish -> addresses 3..7 written with 32'h8B1F03FF on consecutive cycles, then done=1.
REQ-043 DEPTH=8, eight back-to-back transfers -> in_ready=0 after the eighth, done=1, no ninth write.
REQ-044 reset=0 during PAD at address 4 -> next cycle we=0, done=0, state IDLE, and no write to address 5.
